ring_sched: RTL and testbench

- Three-slot round-robin scheduler built around a 2-bit ring state: 0 -> 1 -> 2 -> 0.
- Owns the state register and grants one shared resource to requesters 0..2 in ring order.
- Enforces a bounded hold time per grant.
- Sits between per-slot requesters and the shared datapath. Its state output drives the datapath's slot-select / 'a' input.

---
 rtl/ring_sched.sv | 86 ++++++++
 tb/tb_ring_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ring_sched.sv
// Three-slot round-robin scheduler: a 2-bit ring (0->1->2->0) grants one
// shared resource per slot, with each grant force-released after HOLD_MAX cycles.
module ring_sched #(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    done,
  output logic [2:0]    grant,
  output logic [1:0]    state,
  output logic          busy,
  output logic [CW-1:0] hold_cnt,
  output logic          timeout
);

  typedef enum logic {IDLE, GRANT} phase_t;

  localparam logic [CW-1:0] LIMIT = CW'(HOLD_MAX - 1);

  phase_t     phase;
  logic [3:0] req_x, done_x;
  logic [1:0] next_slot;
  logic       req_cur, done_cur, at_limit;

  // Pad to four bits so the unreachable state 3 still indexes a defined bit.
  assign req_x     = {1'b0, req};
  assign done_x    = {1'b0, done};
  assign req_cur   = req_x[state];
  assign done_cur  = done_x[state];
  assign at_limit  = (hold_cnt == LIMIT);
  assign next_slot = (state == 2'd2) ? 2'd0 : state + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase    <= IDLE;
      state    <= 2'd0;
      grant    <= 3'b000;
      busy     <= 1'b0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == 2'd3) begin
        phase    <= IDLE;
        state    <= 2'd0;
        grant    <= 3'b000;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (phase)
          IDLE: begin
            if (req_cur) begin
              phase    <= GRANT;
              grant    <= 3'b001 << state;
              busy     <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state <= next_slot;
            end
          end
          GRANT: begin
            if (done_cur || at_limit) begin
              // done wins over the limit when both land in the same cycle
              timeout  <= ~done_cur;
              phase    <= IDLE;
              state    <= next_slot;
              grant    <= 3'b000;
              busy     <= 1'b0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: begin
            phase <= IDLE;
            grant <= 3'b000;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_sched.sv
// Scoreboard bench for ring_sched: a driver feeds stimulus and a slot-ownership
// model, pushing expected outputs; a monitor pops and compares each cycle.
module tb_ring_sched;

  localparam int HOLD_MAX = 4;
  localparam int CW       = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    req, done;
  logic [2:0]    grant;
  logic [1:0]    state;
  logic          busy;
  logic [CW-1:0] hold_cnt;
  logic          timeout;

  ring_sched #(.HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .grant(grant), .state(state), .busy(busy),
    .hold_cnt(hold_cnt), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    g;
    logic [1:0]    s;
    logic          b;
    logic [CW-1:0] h;
    logic          t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: which slot the ring points at, whether it currently owns
  // the resource, and how many cycles of ownership have completed.
  int ring = 0;
  bit own  = 0;
  int held = 0;
  bit tout = 0;

  task automatic model_reset();
    ring = 0; own = 0; held = 0; tout = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] d);
    tout = 0;
    if (!own) begin
      if (r[ring]) begin own = 1; held = 0; end
      else ring = (ring + 1) % 3;
    end else if (d[ring]) begin
      own = 0; held = 0; ring = (ring + 1) % 3;
    end else if (held + 1 >= HOLD_MAX) begin
      own = 0; held = 0; ring = (ring + 1) % 3; tout = 1;
    end else begin
      held++;
    end
  endtask

  // Called at posedge+2: drive inputs, predict the outputs after the next edge.
  task automatic cyc(input logic [2:0] r, input logic [2:0] d);
    exp_t e;
    req = r; done = d;
    model_step(r, d);
    e.g = own ? (3'(1) << ring) : 3'b000;
    e.s = 2'(ring);
    e.b = own;
    e.h = CW'(held);
    e.t = tout;
    q.push_back(e);
    @(posedge clock); #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (grant !== 3'b000 || state !== 2'd0 || busy !== 1'b0 ||
        hold_cnt !== '0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s: got grant=%b state=%0d busy=%b hold=%0d timeout=%b, want all zero",
               tag, grant, state, busy, hold_cnt, timeout);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (grant !== e.g || state !== e.s || busy !== e.b ||
            hold_cnt !== e.h || timeout !== e.t) begin
          failures++;
          $display("FAIL cycle@%0t: got g=%b s=%0d b=%b h=%0d t=%b want g=%b s=%0d b=%b h=%0d t=%b",
                   $time, grant, state, busy, hold_cnt, timeout,
                   e.g, e.s, e.b, e.h, e.t);
        end
      end
    end
  end

  initial begin
    bit found;
    reset = 1'b1; req = 3'b000; done = 3'b000;
    #3;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    model_reset();

    // Idle ring walk: 0,1,2,0,1,2.
    repeat (6) cyc(3'b000, 3'b000);

    // Slot 0 granted, released by done after 3 cycles.
    cyc(3'b001, 3'b000);
    cyc(3'b000, 3'b000);
    cyc(3'b000, 3'b000);
    cyc(3'b000, 3'b001);
    repeat (2) cyc(3'b000, 3'b000);

    // Slot 1 held without done: forced release and timeout pulse.
    repeat (12) cyc(3'b010, 3'b000);

    // Slot 2: done[2] coinciding with the limit, stray done[0]/done[1] otherwise.
    for (int i = 0; i < 15; i++)
      cyc(3'b100, (own && ring == 2) ? ((held == HOLD_MAX - 1) ? 3'b111 : 3'b011) : 3'b000);

    // All requesting, done pulsed one cycle into each grant.
    for (int i = 0; i < 14; i++)
      cyc(3'b111, (own && held == 1) ? (3'(1) << ring) : 3'b000);

    // Randomized traffic with varied request/release densities.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] r, d;
      r = 3'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if (i % 150 > 100) r = r | 3'b111;
      cyc(r, d);
    end

    // Reset mid-cycle while slot 1 holds with hold_cnt=2.
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      if (own && ring == 1 && held == 2) found = 1;
      else cyc(3'b010, 3'b000);
    end
    checks++;
    if (!found || grant !== 3'b010 || hold_cnt !== CW'(2)) begin
      failures++;
      $display("FAIL pre_reset_grant: got grant=%b hold=%0d, want grant=010 hold=2", grant, hold_cnt);
    end
    #3 reset = 1'b1;
    #1 check_reset_outputs("async_reset_mid_grant");
    q.delete();
    model_reset();
    req = 3'b000; done = 3'b000;
    @(posedge clock); #1;
    check_reset_outputs("reset_held_over_edge");
    #1 reset = 1'b0;
    cyc(3'b001, 3'b000);
    repeat (3) cyc(3'b000, 3'b000);
    repeat (20) cyc(3'($urandom), 3'($urandom));

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
